// File: rtl/softreg_req_bridge.sv
// Pops softreg requests from a show-ahead FIFO and issues them one at a time on the midas request channel.
// Read data returns as a registered one-cycle strobe; REQ waits on req_ready; WAIT_RESP gives up after TIMEOUT_CYCLES.
module softreg_req_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [63:0] TIMEOUT_DATA   = 64'hDEAD_BEEF_DEAD_BEEF,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [96:0]       fifo_q,
  input  logic              fifo_empty,
  output logic              fifo_rdreq,
  input  logic              io_softreg_req_ready,
  output logic              io_softreg_req_valid,
  output logic [31:0]       io_softreg_req_bits_addr,
  output logic [63:0]       io_softreg_req_bits_wdata,
  output logic              io_softreg_req_bits_wr,
  output logic              io_softreg_resp_ready,
  input  logic              io_softreg_resp_valid,
  input  logic [63:0]       io_softreg_resp_bits_rdata,
  output logic [63:0]       softreg_rddata_out,
  output logic              softreg_rdvalid_out,
  output logic              busy,
  output logic [CNT_W-1:0]  timeout_count
);

  localparam int unsigned    TW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_addr;
  logic [63:0]       r_wdata;
  logic              r_wr;
  logic [TW-1:0]     r_tcnt;
  logic [63:0]       r_rddata;
  logic              r_rdvalid;
  logic [CNT_W-1:0]  r_timeout_count;

  logic w_pop;
  logic w_req_vld;
  logic w_resp_rdy;
  logic w_resp_take;
  logic w_timeout;

  always_comb begin
    w_next      = r_state;
    w_pop       = 1'b0;
    w_req_vld   = 1'b0;
    w_resp_rdy  = 1'b0;
    w_resp_take = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!fifo_empty) begin
          w_pop  = 1'b1;
          w_next = S_REQ;
        end
      end
      S_REQ: begin
        w_req_vld = 1'b1;
        if (io_softreg_req_ready) begin
          w_next = r_wr ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        w_resp_rdy = 1'b1;
        // A response arriving on the last counted cycle takes priority over the timeout.
        if (io_softreg_resp_valid) begin
          w_resp_take = 1'b1;
          w_next      = S_IDLE;
        end else if (r_tcnt == TO_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_wr            <= 1'b0;
      r_tcnt          <= '0;
      r_rddata        <= '0;
      r_rdvalid       <= 1'b0;
      r_timeout_count <= '0;
    end else begin
      r_state   <= w_next;
      r_rdvalid <= w_resp_take | w_timeout;
      if (w_pop) begin
        r_wr    <= fifo_q[96];
        r_addr  <= fifo_q[95:64];
        r_wdata <= fifo_q[63:0];
      end
      if (r_state == S_REQ) begin
        r_tcnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_tcnt <= r_tcnt + TW'(1);
      end
      if (w_resp_take) begin
        r_rddata <= io_softreg_resp_bits_rdata;
      end else if (w_timeout) begin
        r_rddata <= TIMEOUT_DATA;
      end
      if (w_timeout && (r_timeout_count != '1)) begin
        r_timeout_count <= r_timeout_count + CNT_W'(1);
      end
    end
  end

  // Popping is held off while reset is asserted so no FIFO entry is lost to a reset cycle.
  assign fifo_rdreq                = w_pop & rst_n;
  assign io_softreg_req_valid      = w_req_vld;
  assign io_softreg_req_bits_addr  = r_addr;
  assign io_softreg_req_bits_wdata = r_wdata;
  assign io_softreg_req_bits_wr    = r_wr;
  assign io_softreg_resp_ready     = w_resp_rdy;
  assign softreg_rddata_out        = r_rddata;
  assign softreg_rdvalid_out       = r_rdvalid;
  assign busy                      = (r_state != S_IDLE);
  assign timeout_count             = r_timeout_count;

endmodule

// File: tb/tb_softreg_req_bridge.sv
// Bench for softreg_req_bridge: queue-based FIFO and midas target models, a transaction-level
// expectation model checked every cycle, and directed scenarios with hand-computed results.
module tb_softreg_req_bridge;
  localparam int          TO      = 16;
  localparam logic [63:0] TO_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [96:0] fifo_q;
  logic        fifo_empty;
  logic        fifo_rdreq;
  logic        io_softreg_req_ready;
  logic        io_softreg_req_valid;
  logic [31:0] io_softreg_req_bits_addr;
  logic [63:0] io_softreg_req_bits_wdata;
  logic        io_softreg_req_bits_wr;
  logic        io_softreg_resp_ready;
  logic        io_softreg_resp_valid;
  logic [63:0] io_softreg_resp_bits_rdata;
  logic [63:0] softreg_rddata_out;
  logic        softreg_rdvalid_out;
  logic        busy;
  logic [15:0] timeout_count;

  softreg_req_bridge #(.TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(TO_DATA), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq),
    .io_softreg_req_ready(io_softreg_req_ready), .io_softreg_req_valid(io_softreg_req_valid),
    .io_softreg_req_bits_addr(io_softreg_req_bits_addr), .io_softreg_req_bits_wdata(io_softreg_req_bits_wdata),
    .io_softreg_req_bits_wr(io_softreg_req_bits_wr), .io_softreg_resp_ready(io_softreg_resp_ready),
    .io_softreg_resp_valid(io_softreg_resp_valid), .io_softreg_resp_bits_rdata(io_softreg_resp_bits_rdata),
    .softreg_rddata_out(softreg_rddata_out), .softreg_rdvalid_out(softreg_rdvalid_out),
    .busy(busy), .timeout_count(timeout_count)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit checking = 0;

  logic [96:0] fq[$];
  logic [63:0] mem [logic [31:0]];

  bit          rsp_en, rsp_rand, rsp_force, armed;
  int          rsp_delay, cd;
  logic [63:0] rsp_force_data, rdat;

  int          pop_cnt, vld_cnt, rd_hs_cyc;
  int          hs_cyc[$];
  logic [63:0] rdv_dat[$];
  int          rdv_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void drive_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_q     = fifo_empty ? 97'd0 : fq[0];
  endfunction

  task automatic push(input logic wr, input logic [31:0] addr, input logic [63:0] data);
    fq.push_back({wr, addr, data});
    drive_fifo();
  endtask

  task automatic clear_logs();
    pop_cnt = 0; vld_cnt = 0; rd_hs_cyc = 0;
    hs_cyc.delete(); rdv_dat.delete(); rdv_cyc.delete();
  endtask

  // One clock: observe handshakes at the falling edge, update stimulus just after the rising edge.
  task automatic tick();
    bit pop, taken;
    @(negedge clk);
    pop   = (fifo_rdreq === 1'b1);
    taken = io_softreg_resp_valid && (io_softreg_resp_ready === 1'b1);
    if (io_softreg_req_valid === 1'b1) begin
      vld_cnt++;
      if (io_softreg_req_ready) begin
        hs_cyc.push_back(cyc);
        if (io_softreg_req_bits_wr) begin
          mem[io_softreg_req_bits_addr] = io_softreg_req_bits_wdata;
        end else begin
          rd_hs_cyc = cyc;
          if (rsp_en) begin
            armed = 1;
            cd    = rsp_rand ? int'($urandom_range(0, 5)) : rsp_delay;
            if (rsp_force) rdat = rsp_force_data;
            else if (mem.exists(io_softreg_req_bits_addr)) rdat = mem[io_softreg_req_bits_addr];
            else rdat = {32'h0BAD_0000, io_softreg_req_bits_addr};
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pop) begin
      pop_cnt++;
      if (fq.size() > 0) void'(fq.pop_front());
    end
    drive_fifo();
    if (taken) io_softreg_resp_valid = 1'b0;
    if (armed) begin
      if (cd == 0) begin
        io_softreg_resp_valid      = 1'b1;
        io_softreg_resp_bits_rdata = rdat;
        armed = 0;
      end else begin
        cd--;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(fq.size() == 0 && busy === 1'b0 && !armed && !io_softreg_resp_valid) && n < 300) begin
      tick();
      n++;
    end
    chk({name, "_idle_bound"}, (n < 300), 1'b1);
    tick();
    tick();
  endtask

  // Transaction-level expectation: the bridge holds at most one request, taken from the FIFO head.
  bit          m_req, m_wait, m_rdv;
  logic [96:0] m_entry;
  int          m_wcnt;
  logic [63:0] m_rddata;
  logic [15:0] m_to;

  always @(negedge clk) begin
    bit          rdv_n;
    logic [63:0] dat_n;
    if (checking) begin
      chk("req_valid", io_softreg_req_valid, m_req);
      if (m_req) begin
        chk("req_addr",  io_softreg_req_bits_addr,  m_entry[95:64]);
        chk("req_wdata", io_softreg_req_bits_wdata, m_entry[63:0]);
        chk("req_wr",    io_softreg_req_bits_wr,    m_entry[96]);
      end
      chk("resp_ready", io_softreg_resp_ready, m_wait);
      chk("busy",       busy, (m_req || m_wait));
      chk("fifo_rdreq", fifo_rdreq, (rst_n && !m_req && !m_wait && !fifo_empty));
      chk("rdvalid",    softreg_rdvalid_out, m_rdv);
      chk("rddata",     softreg_rddata_out, m_rddata);
      chk("timeout_count", timeout_count, m_to);
      if (softreg_rdvalid_out === 1'b1) begin
        rdv_dat.push_back(softreg_rddata_out);
        rdv_cyc.push_back(cyc);
      end
    end
    if (rst_n !== 1'b1) begin
      m_req = 0; m_wait = 0; m_wcnt = 0; m_rdv = 0;
      m_rddata = '0; m_to = '0; m_entry = '0;
    end else begin
      rdv_n = 0;
      dat_n = m_rddata;
      if (m_wait) begin
        if (io_softreg_resp_valid) begin
          rdv_n = 1; dat_n = io_softreg_resp_bits_rdata; m_wait = 0;
        end else if (m_wcnt == TO - 1) begin
          rdv_n = 1; dat_n = TO_DATA; m_wait = 0;
          if (m_to != 16'hFFFF) m_to++;
        end else begin
          m_wcnt++;
        end
      end else if (m_req) begin
        if (io_softreg_req_ready) begin
          m_req = 0;
          if (!m_entry[96]) begin m_wait = 1; m_wcnt = 0; end
        end
      end else if (!fifo_empty) begin
        m_req = 1;
        m_entry = fifo_q;
      end
      m_rdv    = rdv_n;
      m_rddata = dat_n;
    end
  end

  initial begin
    logic [63:0] exp_rd [4];
    rst_n = 1'b0;
    io_softreg_req_ready = 1'b0;
    io_softreg_resp_valid = 1'b0;
    io_softreg_resp_bits_rdata = '0;
    rsp_en = 1; rsp_rand = 0; rsp_force = 0; rsp_delay = 0; rsp_force_data = '0;
    armed = 0; cd = 0; rdat = '0;
    drive_fifo();
    clear_logs();
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_req_valid", io_softreg_req_valid, 1'b0);
    chk("rst_busy",      busy, 1'b0);
    chk("rst_rdvalid",   softreg_rdvalid_out, 1'b0);
    chk("rst_rddata",    softreg_rddata_out, 64'd0);
    chk("rst_addr",      io_softreg_req_bits_addr, 32'd0);
    chk("rst_to_count",  timeout_count, 16'd0);
    checking = 1;

    // Write then read of the same address.
    io_softreg_req_ready = 1'b1;
    clear_logs();
    push(1'b1, 32'h10, 64'h1122_3344_5566_7788);
    push(1'b0, 32'h10, 64'h0);
    wait_idle("wr_rd");
    chk("wr_rd_pulses", rdv_dat.size(), 1);
    chk("wr_rd_pops",   pop_cnt, 2);
    if (rdv_dat.size() == 1) begin
      chk("wr_rd_data",    rdv_dat[0], 64'h1122_3344_5566_7788);
      chk("wr_rd_latency", rdv_cyc[0] - rd_hs_cyc, 2);
    end

    // Back-to-back writes with ready high: one request every two cycles.
    clear_logs();
    push(1'b1, 32'h100, 64'h1);
    push(1'b1, 32'h104, 64'h2);
    push(1'b1, 32'h108, 64'h3);
    wait_idle("b2b");
    chk("b2b_hs", hs_cyc.size(), 3);
    chk("b2b_pulses", rdv_dat.size(), 0);
    if (hs_cyc.size() == 3) begin
      chk("b2b_gap0", hs_cyc[1] - hs_cyc[0], 2);
      chk("b2b_gap1", hs_cyc[2] - hs_cyc[1], 2);
    end

    // Backpressure: ready low for 7 request cycles, then high.
    io_softreg_req_ready = 1'b0;
    clear_logs();
    push(1'b1, 32'h200, 64'hCAFE_F00D_0123_4567);
    repeat (8) tick();
    io_softreg_req_ready = 1'b1;
    wait_idle("bp");
    chk("bp_valid_cycles", vld_cnt, 8);
    chk("bp_pops",         pop_cnt, 1);
    chk("bp_hs",           hs_cyc.size(), 1);

    // Response lands on the final counted cycle: real data wins.
    clear_logs();
    rsp_force = 1; rsp_force_data = 64'h5A; rsp_delay = TO - 1;
    push(1'b0, 32'h300, 64'h0);
    wait_idle("tocyc");
    chk("tocyc_pulses", rdv_dat.size(), 1);
    chk("tocyc_count",  timeout_count, 16'd0);
    if (rdv_dat.size() == 1) begin
      chk("tocyc_data",    rdv_dat[0], 64'h5A);
      chk("tocyc_latency", rdv_cyc[0] - rd_hs_cyc, TO + 1);
    end

    // Hung target: synthetic response after TO cycles in WAIT_RESP.
    clear_logs();
    rsp_force = 0; rsp_en = 0; rsp_delay = 0;
    push(1'b0, 32'h310, 64'h0);
    wait_idle("tmo");
    chk("tmo_pulses", rdv_dat.size(), 1);
    chk("tmo_count",  timeout_count, 16'd1);
    if (rdv_dat.size() == 1) begin
      chk("tmo_data",    rdv_dat[0], 64'hDEAD_BEEF_DEAD_BEEF);
      chk("tmo_latency", rdv_cyc[0] - rd_hs_cyc, TO + 1);
    end

    // Mixed stream with random 0..5 cycle response delays.
    clear_logs();
    rsp_en = 1; rsp_rand = 1;
    push(1'b1, 32'h1000, 64'h0101_0101_0101_0101);
    push(1'b0, 32'h1000, 64'h0);
    push(1'b1, 32'h1004, 64'h0202_0202_0202_0202);
    push(1'b0, 32'h1004, 64'h0);
    push(1'b0, 32'h1000, 64'h0);
    push(1'b1, 32'h1008, 64'h0303_0303_0303_0303);
    push(1'b0, 32'h1008, 64'h0);
    push(1'b1, 32'h1000, 64'h0404_0404_0404_0404);
    wait_idle("stream");
    exp_rd[0] = 64'h0101_0101_0101_0101;
    exp_rd[1] = 64'h0202_0202_0202_0202;
    exp_rd[2] = 64'h0101_0101_0101_0101;
    exp_rd[3] = 64'h0303_0303_0303_0303;
    chk("stream_pulses", rdv_dat.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rdv_dat.size()) chk($sformatf("stream_data%0d", i), rdv_dat[i], exp_rd[i]);
    end
    chk("stream_empty", fifo_empty, 1'b1);
    chk("stream_busy",  busy, 1'b0);
    chk("stream_hs",    hs_cyc.size(), 8);

    // Reset in the middle of a read.
    clear_logs();
    rsp_en = 0; rsp_rand = 0;
    push(1'b0, 32'h2000, 64'h0);
    repeat (5) tick();
    chk("mid_resp_ready", io_softreg_resp_ready, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_req_valid",  io_softreg_req_valid, 1'b0);
    chk("mid_resp_ready0", io_softreg_resp_ready, 1'b0);
    chk("mid_busy",       busy, 1'b0);
    chk("mid_rdvalid",    softreg_rdvalid_out, 1'b0);
    chk("mid_rddata",     softreg_rddata_out, 64'd0);
    chk("mid_addr",       io_softreg_req_bits_addr, 32'd0);
    chk("mid_wdata",      io_softreg_req_bits_wdata, 64'd0);
    chk("mid_wr",         io_softreg_req_bits_wr, 1'b0);
    chk("mid_to_count",   timeout_count, 16'd0);
    chk("mid_rdreq",      fifo_rdreq, 1'b0);
    repeat (TO + 4) tick();
    chk("mid_no_pulse",   rdv_dat.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/softreg_req_bridge.md
Name: softreg_req_bridge

Overview:
- Drains the 97-bit soft-register request FIFO written by the shell-side softreg front end. Bit 96 is wr, 95:64 is addr, 63:0 is wdata.
- Issues each request on the midas io_softreg valid/ready request channel, one at a time.
- For reads, collects the midas response and returns it to the shell as a one-cycle softreg_rdvalid_out pulse with softreg_rddata_out.
- A response timeout keeps a hung midas target from deadlocking the host.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles to wait in WAIT_RESP before a synthetic read response is returned; must be ≥2.
- TIMEOUT_DATA, 64'hDEAD_BEEF_DEAD_BEEF: read data returned on timeout.
- CNT_W, 16: width of the saturating statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- fifo_q  in  97  show-ahead FIFO head; valid whenever fifo_empty=0
- fifo_empty  in  1  FIFO empty flag
- fifo_rdreq  out  1  pop FIFO head
- io_softreg_req_ready  in  1  midas accepts request
- io_softreg_req_valid  out  1  request valid
- io_softreg_req_bits_addr  out  32  request address
- io_softreg_req_bits_wdata  out  64  write data
- io_softreg_req_bits_wr  out  1  1=write, 0=read
- io_softreg_resp_ready  out  1  bridge accepts response
- io_softreg_resp_valid  in  1  midas response valid
- io_softreg_resp_bits_rdata  in  64  response read data
- softreg_rddata_out  out  64  read data to shell
- softreg_rdvalid_out  out  1  one-cycle read-data strobe
- busy  out  1  state != IDLE
- timeout_count  out  CNT_W  saturating count of read timeouts

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - state=IDLE.
  - All outputs 0, including request bits, softreg_rddata_out and timeout_count.
  - Reset mid-transaction abandons it with no rdvalid pulse. The FIFO entry already popped is lost.
- FSM states: IDLE, REQ, WAIT_RESP.
- IDLE:
  - If fifo_empty=0: fifo_rdreq=1 for exactly this cycle, fifo_q is registered into the request regs, next state REQ.
  - Otherwise fifo_rdreq=0.
- REQ:
  - io_softreg_req_valid=1.
  - addr, wdata and wr are held stable until the handshake (valid&&ready).
  - On handshake: wr=1 → IDLE; wr=0 → WAIT_RESP with the timeout counter cleared.
  - valid never drops before the handshake.
- WAIT_RESP:
  - io_softreg_resp_ready=1.
  - On resp_valid: softreg_rddata_out<=rdata, softreg_rdvalid_out<=1 on the next cycle (registered), → IDLE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 without a response: softreg_rddata_out<=TIMEOUT_DATA, rdvalid pulse, timeout_count+=1 (saturating at all-ones), → IDLE.
  - If resp_valid arrives on the timeout cycle, the real response wins and timeout_count is unchanged.
- io_softreg_resp_ready=0 outside WAIT_RESP; responses presented then are not consumed.
- A late response after a timeout is consumed by the next read. This is a documented limitation; recovery is by reset.
- softreg_rdvalid_out:
  - Exactly one cycle per read, never for writes.
  - softreg_rddata_out holds its last value when rdvalid=0.
- Writes never generate an rdvalid pulse.
- Strictly one outstanding request; FIFO order is preserved.
- Latency:
  - FIFO non-empty at cycle 0 → req_valid at cycle 1.
  - Read with ready=1 at cycle 1 and resp_valid at cycle 2 → rdvalid at cycle 3.
  - Back-to-back writes with ready tied high: one request every 2 cycles.
- busy=1 in REQ and WAIT_RESP.

Test Plan:
- Write then read: push write addr=0x10, wdata=0x1122334455667788, then read addr=0x10. The model returns rdata=0x1122334455667788 one cycle after the read handshake.
  - Required: requests seen in order with exact bits.
  - Required: a single rdvalid pulse carrying 0x1122334455667788.
  - Required: no rdvalid for the write.
- Backpressure: req_ready low for 7 cycles then high. Required: valid held high, addr/wdata/wr stable for all 8 cycles, fifo_rdreq pulsed exactly once.
- Timeout: TIMEOUT_CYCLES=16, read with the response never asserted.
  - Required: rdvalid 16 cycles after entering WAIT_RESP.
  - Required: rddata=0xDEADBEEFDEADBEEF, timeout_count=1.
- Response on the timeout cycle: resp_valid with rdata=0x5A asserted on counter=TIMEOUT_CYCLES-1. Required: rddata=0x5A, timeout_count stays 0.
- Stream: 8 mixed reads/writes, req_ready tied high, resp_valid after random 0–5-cycle delays. Required: 4 rdvalid pulses in order with matching data, FIFO empty at the end, busy=0.
- Reset mid-read: rst_n low for 1 cycle while in WAIT_RESP. Required: next cycle all outputs 0, state IDLE, no rdvalid pulse.
